// File: rtl/regfile_writeback_pkg.sv
// Shared widths, result record and constants for the register-file write-back path.
// No logic; imported by the write-back controller, its queue and its bench.
package wb_pkg;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_result_t;

    localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_writeback_if.sv
// Execute-unit, decode-check and register-file write port bundle of the write-back controller.
// master = producers/decode/register file side, slave = the controller.
interface regfile_writeback_if #(
    parameter int AW = wb_pkg::AW,
    parameter int DW = wb_pkg::DW
);
    logic          Issue_Valid;
    logic [AW-1:0] Issue_Addr;
    logic          ALU_Valid;
    logic [AW-1:0] ALU_Addr;
    logic [DW-1:0] ALU_Data;
    logic          MD_Valid;
    logic [AW-1:0] MD_Addr;
    logic [DW-1:0] MD_Data;
    logic          MD_Ready;
    logic          Alu_Hold;
    logic [AW-1:0] Check_Addr_A;
    logic [AW-1:0] Check_Addr_B;
    logic          Busy_A;
    logic          Busy_B;
    logic          Write_Reg;
    logic [AW-1:0] W_Addr;
    logic [DW-1:0] W_Data;
    logic          Proto_Err;

    modport master (
        output Issue_Valid, Issue_Addr, ALU_Valid, ALU_Addr, ALU_Data,
               MD_Valid, MD_Addr, MD_Data, Check_Addr_A, Check_Addr_B,
        input  MD_Ready, Alu_Hold, Busy_A, Busy_B, Write_Reg, W_Addr, W_Data, Proto_Err
    );

    modport slave (
        input  Issue_Valid, Issue_Addr, ALU_Valid, ALU_Addr, ALU_Data,
               MD_Valid, MD_Addr, MD_Data, Check_Addr_A, Check_Addr_B,
        output MD_Ready, Alu_Hold, Busy_A, Busy_B, Write_Reg, W_Addr, W_Data, Proto_Err
    );
endinterface

// File: rtl/regfile_writeback_result_fifo.sv
// Sync FIFO holding mul/div results; head visible combinationally, push lands next cycle.
// Backpressure via full; a push while full is accepted only together with a pop.
module wb_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_ok   = pop_vld && !empty;
    assign push_ok  = push_vld && (!full || pop_ok);
    assign head_dat = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok) mem[wr_ptr[PW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and queued mul/div results onto the register-file write port, tracks pending writes; commit latency 1.
// MD backpressured by queue full; ALU backpressured by a one-cycle Alu_Hold when a queued result starves.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int DW         = wb_pkg::DW,
    parameter int AW         = wb_pkg::AW,
    parameter int QDEPTH     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                Clk,
    input  logic                Reset_n,
    regfile_writeback_if.slave  wb
);
    localparam int CW = $clog2(STARVE_MAX) + 1;
    localparam int RW = AW + DW;

    logic [RW-1:0]      head_dat;
    logic               q_full;
    logic               q_empty;
    logic               push_vld;
    logic               pop_vld;
    logic               alu_win;
    logic               commit_vld;
    logic [AW-1:0]      commit_addr;
    logic [DW-1:0]      commit_dat;
    logic [CW-1:0]      starve_cnt;
    logic               alu_hold_q;
    logic               proto_err_q;
    logic               write_reg_q;
    logic [AW-1:0]      w_addr_q;
    logic [DW-1:0]      w_data_q;
    logic [2**AW-1:0]   pending;
    logic [2**AW-1:0]   pending_nxt;

    assign push_vld = wb.MD_Valid && !q_full;

    // A hold with a queued head forces the head through and drops any ALU result.
    assign alu_win     = wb.ALU_Valid && !(alu_hold_q && !q_empty);
    assign pop_vld     = !q_empty && !alu_win;
    assign commit_vld  = alu_win || pop_vld;
    assign commit_addr = alu_win ? wb.ALU_Addr : head_dat[RW-1:DW];
    assign commit_dat  = alu_win ? wb.ALU_Data : head_dat[DW-1:0];

    wb_result_fifo #(
        .WIDTH (RW),
        .DEPTH (QDEPTH)
    ) u_md_fifo (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .push_vld (push_vld),
        .push_dat ({wb.MD_Addr, wb.MD_Data}),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            starve_cnt  <= '0;
            alu_hold_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (q_empty || pop_vld)
                starve_cnt <= '0;
            else if (starve_cnt != CW'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
            alu_hold_q  <= (starve_cnt == CW'(STARVE_MAX - 1)) && !q_empty && !pop_vld;
            proto_err_q <= proto_err_q || (wb.ALU_Valid && alu_hold_q);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            write_reg_q <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
        end else begin
            write_reg_q <= commit_vld && (commit_addr != REG_ZERO);
            if (commit_vld) begin
                w_addr_q <= commit_addr;
                w_data_q <= commit_dat;
            end
        end
    end

    // Set after clear so a newly issued producer outlives the older one's commit.
    always_comb begin
        pending_nxt = pending;
        if (commit_vld)     pending_nxt[commit_addr]   = 1'b0;
        if (wb.Issue_Valid) pending_nxt[wb.Issue_Addr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) pending <= '0;
        else          pending <= pending_nxt;
    end

    assign wb.MD_Ready  = !q_full;
    assign wb.Alu_Hold  = alu_hold_q;
    assign wb.Proto_Err = proto_err_q;
    assign wb.Write_Reg = write_reg_q;
    assign wb.W_Addr    = w_addr_q;
    assign wb.W_Data    = w_data_q;
    assign wb.Busy_A    = pending[wb.Check_Addr_A];
    assign wb.Busy_B    = pending[wb.Check_Addr_B];
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed table, starvation/protocol sequences, random run vs queue model.
module tb_regfile_writeback;
    import wb_pkg::*;

    localparam int QD = 2;
    localparam int SM = 4;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    regfile_writeback_if #(.AW(AW), .DW(DW)) bus ();

    regfile_writeback #(.DW(DW), .AW(AW), .QDEPTH(QD), .STARVE_MAX(SM)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .wb      (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.Issue_Valid  = 1'b0;
        bus.Issue_Addr   = '0;
        bus.ALU_Valid    = 1'b0;
        bus.ALU_Addr     = '0;
        bus.ALU_Data     = '0;
        bus.MD_Valid     = 1'b0;
        bus.MD_Addr      = '0;
        bus.MD_Data      = '0;
        bus.Check_Addr_A = '0;
        bus.Check_Addr_B = '0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
    endtask

    // Reference model: a result queue, per-register pending flags and a count of consecutive lost cycles.
    wb_result_t       mq[$];
    bit [31:0]        pend_m;
    int               lost;
    bit               hold_m, proto_m, wr_m;
    logic [AW-1:0]    wa_m;
    logic [DW-1:0]    wd_m;

    task automatic model_reset();
        mq.delete();
        pend_m = '0; lost = 0; hold_m = 0; proto_m = 0; wr_m = 0;
        wa_m = '0; wd_m = '0;
    endtask

    task automatic model_step();
        wb_result_t c;
        bit commit = 0;
        bit popped = 0;
        int n = mq.size();
        c = '0;
        if (hold_m && n > 0) begin
            c = mq.pop_front(); popped = 1; commit = 1;
            if (bus.ALU_Valid) proto_m = 1;
        end else if (bus.ALU_Valid) begin
            c.addr = bus.ALU_Addr; c.data = bus.ALU_Data; commit = 1;
        end else if (n > 0) begin
            c = mq.pop_front(); popped = 1; commit = 1;
        end
        if (bus.MD_Valid && n < QD) begin
            wb_result_t r;
            r.addr = bus.MD_Addr; r.data = bus.MD_Data;
            mq.push_back(r);
        end
        if (n > 0 && !popped) lost++;
        else                  lost = 0;
        hold_m = (lost == SM);
        wr_m = commit && (c.addr != 0);
        if (commit) begin
            pend_m[c.addr] = 1'b0;
            wa_m = c.addr;
            wd_m = c.data;
        end
        if (bus.Issue_Valid && bus.Issue_Addr != 0) pend_m[bus.Issue_Addr] = 1'b1;
    endtask

    typedef struct {
        logic        iv;
        logic [4:0]  ia;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic [4:0]  chk;
        logic        busy_pre;
        logic        e_wr;
        logic        chk_wd;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        busy_post;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        Reset_n = 1'b0;
        idle_inputs();
        #1;
        check("rst_write_reg", bus.Write_Reg, 0);
        check("rst_w_addr", bus.W_Addr, 0);
        check("rst_w_data", bus.W_Data, 0);
        check("rst_alu_hold", bus.Alu_Hold, 0);
        check("rst_proto_err", bus.Proto_Err, 0);
        check("rst_md_ready", bus.MD_Ready, 1);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        tick();
        check("idle_write_reg", bus.Write_Reg, 0);
        check("idle_md_ready", bus.MD_Ready, 1);
        for (int a = 0; a < 32; a++) begin
            bus.Check_Addr_A = 5'(a);
            bus.Check_Addr_B = 5'(31 - a);
            #1;
            check("idle_busy_a", bus.Busy_A, 0);
            check("idle_busy_b", bus.Busy_B, 0);
        end
        tick();

        // Directed ALU/scoreboard vectors applied back to back from the idle state.
        vecs[0] = '{1, 7,  0, 0,  32'h0,        7,  0, 0, 1, 0,  32'h0,        1};
        vecs[1] = '{0, 0,  1, 7,  32'hDEADBEEF, 7,  1, 1, 1, 7,  32'hDEADBEEF, 0};
        vecs[2] = '{1, 0,  1, 0,  32'h5,        0,  0, 0, 0, 0,  32'h0,        0};
        vecs[3] = '{1, 9,  1, 9,  32'h99,       9,  0, 1, 1, 9,  32'h99,       1};
        vecs[4] = '{0, 0,  0, 0,  32'h0,        9,  1, 0, 1, 9,  32'h99,       1};
        vecs[5] = '{0, 0,  1, 9,  32'h1234,     9,  1, 1, 1, 9,  32'h1234,     0};
        vecs[6] = '{1, 31, 1, 31, 32'hFFFFFFFF, 31, 0, 1, 1, 31, 32'hFFFFFFFF, 1};
        for (int i = 0; i < 7; i++) begin
            bus.Issue_Valid  = vecs[i].iv;
            bus.Issue_Addr   = vecs[i].ia;
            bus.ALU_Valid    = vecs[i].av;
            bus.ALU_Addr     = vecs[i].aa;
            bus.ALU_Data     = vecs[i].ad;
            bus.Check_Addr_A = vecs[i].chk;
            bus.Check_Addr_B = vecs[i].chk;
            #1;
            check("vec_busy_a_pre", bus.Busy_A, vecs[i].busy_pre);
            check("vec_busy_b_pre", bus.Busy_B, vecs[i].busy_pre);
            tick();
            idle_inputs();
            bus.Check_Addr_A = vecs[i].chk;
            #1;
            check("vec_write_reg", bus.Write_Reg, vecs[i].e_wr);
            if (vecs[i].chk_wd) begin
                check("vec_w_addr", bus.W_Addr, vecs[i].e_wa);
                check("vec_w_data", bus.W_Data, vecs[i].e_wd);
            end
            check("vec_busy_a_post", bus.Busy_A, vecs[i].busy_post);
        end

        // Starvation: ALU always busy, two MD results must each be forced through by a hold.
        do_reset();
        bus.ALU_Valid = 1; bus.ALU_Addr = 5'd1; bus.ALU_Data = 32'hA1;
        bus.MD_Valid = 1; bus.MD_Addr = 5'd3; bus.MD_Data = 32'h11;
        tick();
        bus.MD_Addr = 5'd4; bus.MD_Data = 32'h22;
        tick();
        bus.MD_Valid = 0;
        check("starve_md_ready_full", bus.MD_Ready, 0);
        n = 1;
        while (!bus.Alu_Hold && n < 20) begin tick(); n++; end
        check("starve_hold1_delay", n, SM);
        bus.ALU_Valid = 0;
        tick();
        check("starve_commit1_wr", bus.Write_Reg, 1);
        check("starve_commit1_addr", bus.W_Addr, 3);
        check("starve_commit1_data", bus.W_Data, 32'h11);
        check("starve_hold1_pulse", bus.Alu_Hold, 0);
        check("starve_md_ready_freed", bus.MD_Ready, 1);
        bus.ALU_Valid = 1;
        n = 0;
        while (!bus.Alu_Hold && n < 20) begin tick(); n++; end
        check("starve_hold2_delay", n, SM);
        bus.ALU_Valid = 0;
        tick();
        check("starve_commit2_addr", bus.W_Addr, 4);
        check("starve_commit2_data", bus.W_Data, 32'h22);
        check("starve_proto_clean", bus.Proto_Err, 0);

        // Protocol violation: ALU presented during the hold is dropped and flagged.
        bus.ALU_Valid = 1;
        bus.MD_Valid = 1; bus.MD_Addr = 5'd5; bus.MD_Data = 32'h55;
        tick();
        bus.MD_Valid = 0;
        n = 0;
        while (!bus.Alu_Hold && n < 20) begin tick(); n++; end
        check("proto_hold_seen", bus.Alu_Hold, 1);
        bus.ALU_Addr = 5'd6; bus.ALU_Data = 32'h66;
        tick();
        check("proto_head_addr", bus.W_Addr, 5);
        check("proto_head_data", bus.W_Data, 32'h55);
        check("proto_err_set", bus.Proto_Err, 1);
        bus.ALU_Valid = 0;
        repeat (3) tick();
        check("proto_err_sticky", bus.Proto_Err, 1);

        // Random run against the model, with an asynchronous reset mid-burst.
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            bus.Issue_Valid  = $urandom_range(0, 1);
            bus.Issue_Addr   = 5'($urandom_range(0, 7));
            bus.ALU_Valid    = ($urandom_range(0, 9) < 8) && (!hold_m || $urandom_range(0, 7) == 0);
            bus.ALU_Addr     = 5'($urandom_range(0, 7));
            bus.ALU_Data     = $urandom;
            bus.MD_Valid     = $urandom_range(0, 1);
            bus.MD_Addr      = 5'($urandom_range(0, 7));
            bus.MD_Data      = $urandom;
            bus.Check_Addr_A = 5'($urandom_range(0, 7));
            bus.Check_Addr_B = 5'($urandom_range(0, 31));
            #1;
            check("rnd_md_ready", bus.MD_Ready, mq.size() < QD);
            check("rnd_busy_a", bus.Busy_A, pend_m[bus.Check_Addr_A]);
            check("rnd_busy_b", bus.Busy_B, pend_m[bus.Check_Addr_B]);
            model_step();
            tick();
            check("rnd_write_reg", bus.Write_Reg, wr_m);
            if (wr_m) begin
                check("rnd_w_addr", bus.W_Addr, wa_m);
                check("rnd_w_data", bus.W_Data, wd_m);
            end
            check("rnd_alu_hold", bus.Alu_Hold, hold_m);
            check("rnd_proto_err", bus.Proto_Err, proto_m);
            if (i == 200) begin
                #2;
                Reset_n = 1'b0;
                #1;
                check("arst_write_reg", bus.Write_Reg, 0);
                check("arst_w_addr", bus.W_Addr, 0);
                check("arst_w_data", bus.W_Data, 0);
                check("arst_alu_hold", bus.Alu_Hold, 0);
                check("arst_proto_err", bus.Proto_Err, 0);
                check("arst_md_ready", bus.MD_Ready, 1);
                check("arst_busy_a", bus.Busy_A, 0);
                check("arst_busy_b", bus.Busy_B, 0);
                model_reset();
                idle_inputs();
                @(negedge Clk);
                Reset_n = 1'b1;
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
